// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, frame length and command constants
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_ERR
    } ps2_state_t;

    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 2-flop synchronizers for PS/2 clk/data plus clk falling-edge pulse
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s,
    output logic data_s,
    output logic clk_fe
);

    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_s     <= clk_meta;
            clk_prev  <= clk_s;
            data_meta <= ps2_data_i;
            data_s    <= data_meta;
        end
    end

    assign clk_fe = clk_prev & ~clk_s;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter; optional timeout under PS2_HOST_TX_TIMEOUT_EN
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int         INH_W       = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [3:0] LAST_SHIFT_K = 4'(FRAME_EDGES - 2);

    ps2_state_t       state;
    ps2_state_t       state_next;
    logic [7:0]       tx_byte;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       edge_cnt;
    logic             data_drv;
    logic             clk_s;
    logic             data_s;
    logic             clk_fe;
    logic             inh_last;
    logic             in_frame;
    logic             timeout_hit;

    ps2_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .clk_s      (clk_s),
        .data_s     (data_s),
        .clk_fe     (clk_fe)
    );

    assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign in_frame = (state == ST_SHIFT) || (state == ST_ACK) || (state == ST_WAIT_IDLE);

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == ST_REQ) begin
            to_cnt <= '0;
        end else if (in_frame) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_frame && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (tx_valid) state_next = ST_INHIBIT;
            ST_INHIBIT:   if (inh_last) state_next = ST_REQ;
            ST_REQ:       state_next = ST_SHIFT;
            ST_SHIFT: begin
                if (timeout_hit)                                state_next = ST_ERR;
                else if (clk_fe && edge_cnt == LAST_SHIFT_K)    state_next = ST_ACK;
            end
            ST_ACK: begin
                if (timeout_hit) state_next = ST_ERR;
                else if (clk_fe) state_next = data_s ? ST_ERR : ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (timeout_hit)          state_next = ST_ERR;
                else if (clk_s && data_s) state_next = ST_DONE;
            end
            ST_DONE:      state_next = ST_IDLE;
            ST_ERR:       state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // edge_cnt holds the number of falling edges already seen, so fe number = edge_cnt + 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_byte  <= '0;
            inh_cnt  <= '0;
            edge_cnt <= '0;
            data_drv <= 1'b0;
        end else begin
            if (state == ST_IDLE && tx_valid) tx_byte <= tx_data;
            inh_cnt <= (state == ST_INHIBIT) ? inh_cnt + 1'b1 : '0;
            if (state == ST_REQ) begin
                edge_cnt <= '0;
                data_drv <= 1'b1;
            end else if (state == ST_SHIFT && clk_fe) begin
                edge_cnt <= edge_cnt + 1'b1;
                if (edge_cnt < 4'd8)       data_drv <= ~tx_byte[edge_cnt[2:0]];
                else if (edge_cnt == 4'd8) data_drv <= ~odd_parity(tx_byte);
                else                       data_drv <= 1'b0;
            end
        end
    end

    always_comb begin
        tx_ready    = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        err         = (state == ST_ERR);
        ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
        ps2_data_oe = (state == ST_REQ) || ((state == ST_SHIFT) && data_drv);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed scoreboard bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 3000;
    localparam int TO  = 4000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, err;
    logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int base_d, base_e;
    logic       evt_prev = 1'b0;
    logic       post_rdy = 1'b0;
    logic [1:0] post_oe  = 2'b00;
    logic       par_seen;
    logic       exp_q[$];
    int         out_q[$];
    logic [7:0] par_b[4] = '{8'h00, 8'hFF, 8'h01, 8'h80};
    logic       par_e[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    assign ps2_clk_i  = ps2_clk_oe  ? 1'b0 : dev_clk;
    assign ps2_data_i = ps2_data_oe ? 1'b0 : dev_data;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_prev) begin
            post_rdy <= tx_ready;
            post_oe  <= {ps2_clk_oe, ps2_data_oe};
        end
        evt_prev <= done | err;
        if (done)        done_cnt <= done_cnt + 1;
        if (err)         err_cnt  <= err_cnt + 1;
        if (done && err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && w < 100) begin @(negedge clk); w++; end
        chk("send_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~b;
        chk("inhibit_start", ps2_clk_oe, 1);
    endtask

    task automatic wait_shift();
        int w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && w < INH + 100) begin
            @(negedge clk); w++;
        end
        chk("shift_entry", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    endtask

    // Device side: samples data at its rising edges, then ACKs (data low) or NACKs at edge 11.
    task automatic dev_frame(input logic [7:0] b, input bit ack);
        logic obs;
        base_d = done_cnt;
        base_e = err_cnt;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        exp_q.push_back(~^b);
        exp_q.push_back(1'b1);
        wait_shift();
        obs = ps2_data_i;
        chk("start_bit", obs, exp_q.pop_front());
        for (int e = 1; e <= 10; e++) begin
            repeat (H) @(negedge clk);
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            obs = ps2_data_i;
            if (e == 9) par_seen = obs;
            chk($sformatf("bit_e%0d_%02h", e, b), obs, exp_q.pop_front());
            dev_clk = 1'b1;
        end
        repeat (H / 2) @(negedge clk);
        dev_data = ack ? 1'b0 : 1'b1;
        repeat (H / 2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic finish_frame();
        int w = 0;
        int kind;
        while (done_cnt + err_cnt == base_d + base_e && w < 200) begin @(negedge clk); w++; end
        repeat (2) @(negedge clk);
        if (done_cnt == base_d + 1 && err_cnt == base_e)      kind = 1;
        else if (err_cnt == base_e + 1 && done_cnt == base_d) kind = 2;
        else                                                  kind = 0;
        chk("outcome", kind, out_q.pop_front());
        chk("post_ready_oe", {post_rdy, post_oe}, 3'b100);
        chk("done_err_overlap", both_cnt, 0);
    endtask

    initial begin
        int cnt;
        int d0, e0;
        rst_n    = 1'b0;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe}, 6'b100000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", {tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe}, 6'b100000);

        // 0xED: inhibit length, REQ, frame bits, ACK
        send(CMD_SET_LED);
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < INH + 10) begin cnt++; @(negedge clk); end
        chk("inhibit_cycles", cnt, INH);
        chk("req_both_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
        @(negedge clk);
        chk("clk_release", {ps2_clk_oe, busy}, 2'b01);
        out_q.push_back(1);
        dev_frame(CMD_SET_LED, 1'b1);
        finish_frame();

        for (int i = 0; i < 4; i++) begin
            send(par_b[i]);
            out_q.push_back(1);
            dev_frame(par_b[i], 1'b1);
            chk($sformatf("parity_%02h", par_b[i]), par_seen, par_e[i]);
            finish_frame();
        end

        // NACK
        send(CMD_SET_LED);
        out_q.push_back(2);
        dev_frame(CMD_SET_LED, 1'b0);
        finish_frame();

        // tx_valid held high: 0xF4 waits for 0xFF to finish
        @(negedge clk);
        tx_data  = CMD_RESET;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = CMD_ENABLE;
        chk("b2b_first_start", ps2_clk_oe, 1);
        out_q.push_back(1);
        dev_frame(CMD_RESET, 1'b1);
        cnt = 0;
        while (!done && cnt < 50) begin @(negedge clk); cnt++; end
        chk("b2b_done_ready", {done, tx_ready}, 2'b10);
        @(negedge clk);
        chk("b2b_ready_after_done", {tx_ready, ps2_clk_oe}, 2'b10);
        @(negedge clk);
        chk("b2b_second_start", ps2_clk_oe, 1);
        tx_valid = 1'b0;
        finish_frame();
        out_q.push_back(1);
        dev_frame(CMD_ENABLE, 1'b1);
        finish_frame();

        // reset during falling edge 5
        send(CMD_SET_LED);
        wait_shift();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int e = 1; e <= 4; e++) begin
            repeat (H) @(negedge clk); dev_clk = 1'b0;
            repeat (H) @(negedge clk); dev_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_oe_drop", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {tx_ready, busy}, 2'b10);
        chk("rst_no_evt", {done_cnt - d0, err_cnt - e0}, 64'd0);

        // device never clocks
        send(CMD_ENABLE);
        wait_shift();
        d0 = done_cnt;
        e0 = err_cnt;
`ifdef PS2_HOST_TX_TIMEOUT_EN
        cnt = 0;
        while (!err && cnt < 2 * TO) begin @(negedge clk); cnt++; end
        chk("timeout_cycles", cnt, TO);
        @(negedge clk);
        chk("timeout_ready", {tx_ready, ps2_clk_oe, ps2_data_oe}, 3'b100);
        chk("timeout_counts", {done_cnt - d0, err_cnt - e0}, {32'd0, 32'd1});
`else
        repeat (2 * TO) @(negedge clk);
        chk("stall_busy", {busy, tx_ready}, 2'b10);
        chk("stall_no_evt", {done_cnt - d0, err_cnt - e0}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("stall_recover", tx_ready, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same PS2_CLK/PS2_DATA lines the keyboard decoder listens on. It runs the request-to-send sequence, shifts out an 11-bit frame on device-generated clocks, checks the device ACK, and reports done or err. The top level implements open-drain with `PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz` (same form for data). The top level ignores decoder output while `busy` is high.

## Interface
- INHIBIT_CYCLES, 12000: cycles PS2_CLK is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 1500000: frame timeout, counted from SHIFT entry (15 ms at 100 MHz).
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte; latched at accept.
- tx_valid  in  1  send request.
- tx_ready  out  1  high only in IDLE; a frame is accepted on the cycle where `tx_valid && tx_ready`.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame sent, ACK received, lines idle.
- err  out  1  one-cycle pulse: NACK or timeout. Never asserted in the same cycle as done.
- ps2_clk_i, ps2_data_i  in  1  raw line levels (asynchronous).
- ps2_clk_oe, ps2_data_oe  out  1  1 = pull the line low, 0 = release it.

## Operation
- Line inputs:
  - ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer.
  - A falling edge (`fe`) is synchronized clk 1 in the previous cycle and 0 in the current cycle.
- States: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE, DONE, ERR.
- IDLE: both oe = 0, tx_ready = 1. On accept: latch tx_data, go to INHIBIT.
- INHIBIT: clk_oe = 1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle): clk_oe = 1, data_oe = 1 (start bit 0). Then go to SHIFT.
- SHIFT: clk_oe = 0. A 4-bit edge counter k is cleared on SHIFT entry and incremented on each fe.
  - fe number 1..8: data_oe = ~byte[k-1] (LSB first).
  - fe number 9: data_oe = ~parity, where parity = ~^byte (odd parity).
  - fe number 10: data_oe = 0 (stop bit 1); go to ACK.
- ACK: on the next fe, sample synchronized data.
  - 0 → WAIT_IDLE.
  - 1 → ERR (NACK).
- WAIT_IDLE: when synchronized clk and data are both 1, go to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- ERR: err = 1 for one cycle, both oe = 0, then IDLE.
- tx_valid while busy is ignored. tx_data changes after accept are ignored.
- Reset value of every output: ps2_clk_oe = 0, ps2_data_oe = 0, done = 0, err = 0, busy = 0, tx_ready = 1.
- Reset mid-frame: both oe drop asynchronously. No done or err is issued. State returns to IDLE.

## Timing
- Accept at cycle N:
  - clk_oe rises at N+1.
  - data_oe rises at N+1+INHIBIT_CYCLES.
  - clk_oe falls at N+2+INHIBIT_CYCLES.
- Data update latency: 3 cycles after the raw PS2_CLK falling edge (2 synchronizer stages + 1 register). This is well inside the ≥30 us clock-low time.
- done follows the line-idle detection by 1 cycle. tx_ready rises the cycle after done or err, so back-to-back frames are possible.
- Timeout (under macro): one counter from SHIFT entry through WAIT_IDLE. Reaching TIMEOUT_CYCLES-1 forces ERR from any of those states.

## Configuration
- PS2_HOST_TX_TIMEOUT_EN defined: timeout counter present; a stalled device produces err.
- PS2_HOST_TX_TIMEOUT_EN undefined: no counter. SHIFT/ACK/WAIT_IDLE wait indefinitely and only rst recovers the block.

## Structure
- Package ps2_pkg:
  - state enum;
  - FRAME_EDGES = 11;
  - command constants: CMD_SET_LED 8'hED, CMD_ENABLE 8'hF4, CMD_RESET 8'hFF, RESP_ACK 8'hFA.
- Sub-module ps2_sync_edge: 2-flop synchronizers for both lines plus clk falling-edge pulse. This module is reusable by the receiver.

## Test plan
- Send 0xED; device model clocks and ACKs:
  - clk_oe held low exactly 12000 cycles;
  - data sampled on device rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - one done pulse, err stays 0.
- Parity: 0x00 → 1, 0xFF → 1, 0x01 → 0, 0x80 → 0, each checked on the device rising edge after fe number 9.
- NACK: device leaves data high at edge 11 → err pulse, no done, both oe = 0, tx_ready = 1 the next cycle.
- Timeout (macro on): device never clocks → err exactly TIMEOUT_CYCLES cycles after SHIFT entry. Macro off: still busy after 2×TIMEOUT_CYCLES.
- tx_valid held high with 0xF4 while sending 0xFF → 0xF4 sent only after done; both frames bit-correct.
- rst low during fe number 5 → both oe = 0 within the same cycle, no done/err, tx_ready = 1 after rst is released.
